// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the two-requester memory port arbiter:
//   - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2)
//   - transaction owner encoding (DATA=0, FETCH=1)
//   - default starvation limit for the fetch requester
//   - the arbitration decision as a pure combinational function
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        DATA  = 1'b0,
        FETCH = 1'b1
    } owner_e;

    typedef struct packed {
        logic data;
        logic fetch;
    } grant_t;

    // Grants are only possible in IDLE. Data has priority unless the fetch
    // side has already watched starve_limit consecutive data grants go by.
    function automatic grant_t arb_decide(
        input arb_state_e  state,
        input logic        d_req,
        input logic        i_req,
        input int unsigned starve_cnt,
        input int unsigned starve_limit
    );
        grant_t g;
        g = '0;
        if (state == IDLE) begin
            if (i_req && (!d_req || starve_cnt == starve_limit)) begin
                g.fetch = 1'b1;
            end else if (d_req) begin
                g.data = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the data requester, fetch requester and memory-side signals of the
// arbiter.
//   slave  : the arbiter's view (takes requests, drives grants/responses and
//            the memory command, takes memory handshakes)
//   master : the environment's view (requesters plus memory)
// Data side  : d_req, d_addr, d_wdata, d_we -> d_gnt, d_rvalid, d_rdata
// Fetch side : i_req, i_addr               -> i_gnt, i_rvalid, i_rdata
// Memory     : mem_addr, mem_wdata, mem_we, mem_re <- mem_ready, mem_rvalid,
//              mem_rdata
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    // data requester (execute-stage load/store)
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    // fetch requester (read-only)
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    // memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        mem_re;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  d_req, d_addr, d_wdata, d_we,
        output d_gnt, d_rvalid, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output d_req, d_addr, d_wdata, d_we,
        input  d_gnt, d_rvalid, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between a data (load/store) requester and an
// instruction-fetch requester, one outstanding transaction at a time.
//   IDLE  : combinational grant to one requester; payload captured at the
//           grant edge into the mem_* registers
//   ISSUE : mem_* held stable until mem_ready; writes finish here with a
//           one-cycle d_rvalid acknowledge (d_rdata = 0)
//   WAIT  : waits for mem_rvalid, returns mem_rdata to the owner next cycle
// Data normally wins; fetch wins once STARVE_LIMIT consecutive data grants
// have passed while it was pending.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requesters and memory)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state,        state_next;
    owner_e           owner,        owner_next;
    logic [CNT_W-1:0] starve_cnt,   starve_cnt_next;
    logic [31:0]      mem_addr_q,   mem_addr_next;
    logic [31:0]      mem_wdata_q,  mem_wdata_next;
    logic [3:0]       mem_we_q,     mem_we_next;
    logic             mem_re_q,     mem_re_next;
    logic             d_rvalid_q,   d_rvalid_next;
    logic             i_rvalid_q,   i_rvalid_next;
    logic [31:0]      d_rdata_q,    d_rdata_next;
    logic [31:0]      i_rdata_q,    i_rdata_next;
    grant_t           grant;

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the response data registers are reset too, so a reset
            // mid-transaction leaves no stale read data visible.
            state       <= IDLE;
            owner       <= DATA;
            starve_cnt  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= '0;
            mem_re_q    <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
            i_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state       <= state_next;
            owner       <= owner_next;
            starve_cnt  <= starve_cnt_next;
            mem_addr_q  <= mem_addr_next;
            mem_wdata_q <= mem_wdata_next;
            mem_we_q    <= mem_we_next;
            mem_re_q    <= mem_re_next;
            d_rvalid_q  <= d_rvalid_next;
            i_rvalid_q  <= i_rvalid_next;
            d_rdata_q   <= d_rdata_next;
            i_rdata_q   <= i_rdata_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch;
        // registers hold by default and rvalid pulses fall by default.
        state_next      = state;
        owner_next      = owner;
        starve_cnt_next = starve_cnt;
        mem_addr_next   = mem_addr_q;
        mem_wdata_next  = mem_wdata_q;
        mem_we_next     = mem_we_q;
        mem_re_next     = mem_re_q;
        d_rvalid_next   = 1'b0;
        i_rvalid_next   = 1'b0;
        d_rdata_next    = d_rdata_q;
        i_rdata_next    = i_rdata_q;

        grant = arb_decide(state, bus.d_req, bus.i_req, 32'(starve_cnt), STARVE_LIMIT);

        unique case (state)
            IDLE: begin
                // Fetch not waiting: its starvation history is irrelevant.
                if (!bus.i_req) begin
                    starve_cnt_next = '0;
                end
                if (grant.data) begin
                    mem_addr_next  = bus.d_addr;
                    mem_wdata_next = bus.d_wdata;
                    mem_we_next    = bus.d_we;
                    mem_re_next    = (bus.d_we == 4'b0000);
                    owner_next     = DATA;
                    state_next     = ISSUE;
                    if (bus.i_req && starve_cnt != CNT_MAX) begin
                        starve_cnt_next = starve_cnt + CNT_W'(1);
                    end
                end else if (grant.fetch) begin
                    mem_addr_next   = bus.i_addr;
                    mem_wdata_next  = '0;
                    mem_we_next     = 4'b0000;
                    mem_re_next     = 1'b1;
                    owner_next      = FETCH;
                    state_next      = ISSUE;
                    starve_cnt_next = '0;
                end
            end

            ISSUE: begin
                if (bus.mem_ready) begin
                    mem_we_next = 4'b0000;
                    mem_re_next = 1'b0;
                    if (mem_re_q) begin
                        state_next = WAIT;
                    end else begin
                        // Writes only come from the data side; acknowledge
                        // with a zero-data response pulse.
                        state_next    = IDLE;
                        d_rvalid_next = 1'b1;
                        d_rdata_next  = '0;
                    end
                end
            end

            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_next = IDLE;
                    if (owner == DATA) begin
                        d_rdata_next  = bus.mem_rdata;
                        d_rvalid_next = 1'b1;
                    end else begin
                        i_rdata_next  = bus.mem_rdata;
                        i_rvalid_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.d_gnt     = grant.data;
    assign bus.i_gnt     = grant.fetch;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Expected responses are queued when
// a request is driven; a monitor pops and compares on every rvalid. Memory
// handshakes come either from scenario tasks (manual) or from a small
// auto-responding memory model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        fetch;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    // memory-side drive: manual from tasks, or automatic from the model
    logic        auto_mem;
    logic        man_ready,  auto_ready;
    logic        man_rvalid, auto_rvalid;
    logic [31:0] man_rdata,  auto_rdata;
    logic        rd_pending;
    logic [31:0] rd_addr;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_ready  = auto_mem ? auto_ready  : man_ready;
    assign bus.mem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
    assign bus.mem_rdata  = auto_mem ? auto_rdata  : man_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Auto memory: ready in the first ISSUE cycle, read data one cycle later.
    initial begin
        auto_ready  = 1'b0;
        auto_rvalid = 1'b0;
        auto_rdata  = '0;
        rd_pending  = 1'b0;
        rd_addr     = '0;
    end

    always @(posedge clk) begin
        #1;
        auto_ready  = 1'b0;
        auto_rvalid = 1'b0;
        if (rd_pending) begin
            auto_rvalid = 1'b1;
            auto_rdata  = mem_fn(rd_addr);
            rd_pending  = 1'b0;
        end
        if (auto_mem && (bus.mem_re || bus.mem_we != 4'b0000)) begin
            auto_ready = 1'b1;
            if (bus.mem_re) begin
                rd_pending = 1'b1;
                rd_addr    = bus.mem_addr;
            end
        end
    end

    // Response monitor / scoreboard consumer.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (bus.d_gnt || bus.i_gnt) begin
            checks++;
            if (bus.d_gnt && bus.i_gnt) begin
                errors++;
                $display("FAIL both_gnt: d_gnt=1 i_gnt=1, required exactly one at t=%0t", $time);
            end
        end
        if (bus.d_rvalid || bus.i_rvalid) begin
            checks++;
            if (bus.d_rvalid && bus.i_rvalid) begin
                errors++;
                $display("FAIL both_rvalid: d_rvalid=1 i_rvalid=1 at t=%0t", $time);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: d_rvalid=%b i_rvalid=%b with nothing outstanding at t=%0t",
                         bus.d_rvalid, bus.i_rvalid, $time);
            end else begin
                e   = sb.pop_front();
                got = bus.i_rvalid ? bus.i_rdata : bus.d_rdata;
                if (bus.i_rvalid !== e.fetch || got !== e.data) begin
                    errors++;
                    $display("FAIL response: got fetch=%b data=%h, expected fetch=%b data=%h at t=%0t",
                             bus.i_rvalid, got, e.fetch, e.data, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits up to 50 cycles for the scoreboard to empty.
    task automatic wait_drain(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid, bus.mem_re, bus.mem_we,
             bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.i_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b re=%b we=%b addr=%h wdata=%h drd=%h ird=%h, required all 0",
                     bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid, bus.mem_re, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.i_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_data_read();
        bit to;
        @(posedge clk); #1;                       // cycle 0
        bus.d_req = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'h5555_AAAA; bus.d_we = 4'b0000;
        sb.push_back('{fetch: 1'b0, data: 32'hDEAD_BEEF});
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rd_gnt: d_gnt,i_gnt=%b, expected 10", {bus.d_gnt, bus.i_gnt});
        end
        @(posedge clk); #1;                       // cycle 1: ISSUE
        bus.d_req = 1'b0; bus.d_addr = 32'hFFF; man_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.mem_addr} !== {1'b1, 4'b0000, 32'h100}) begin
            errors++;
            $display("FAIL rd_issue: re=%b we=%b addr=%h, expected re=1 we=0 addr=00000100",
                     bus.mem_re, bus.mem_we, bus.mem_addr);
        end
        @(posedge clk); #1;                       // cycle 2: WAIT
        man_ready = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.d_gnt, bus.d_rvalid} !== 7'b0) begin
            errors++;
            $display("FAIL rd_wait: re=%b we=%b gnt=%b rvalid=%b, expected all 0",
                     bus.mem_re, bus.mem_we, bus.d_gnt, bus.d_rvalid);
        end
        @(posedge clk); #1;                       // cycle 3: response
        man_rvalid = 1'b0; man_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_resp: d_rvalid=%b i_rvalid=%b d_rdata=%h, expected 1 0 deadbeef",
                     bus.d_rvalid, bus.i_rvalid, bus.d_rdata);
        end
        @(negedge clk);                           // cycle 4: pulse over, data held
        checks++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_hold: d_rvalid=%b d_rdata=%h, expected 0 deadbeef", bus.d_rvalid, bus.d_rdata);
        end
        wait_drain(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rd_drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_data_write();
        bit to;
        @(posedge clk); #1;                       // cycle 0
        bus.d_req = 1'b1; bus.d_addr = 32'h203; bus.d_wdata = 32'hA5A5_1234; bus.d_we = 4'b1000;
        sb.push_back('{fetch: 1'b0, data: 32'h0});
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL wr_gnt: d_gnt,i_gnt=%b, expected 10", {bus.d_gnt, bus.i_gnt});
        end
        for (int c = 1; c <= 3; c++) begin        // ISSUE, ready on the third
            @(posedge clk); #1;
            bus.d_req = 1'b0; bus.d_we = 4'b0001;
            man_ready = (c == 3);
            @(negedge clk);
            checks++;
            if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}
                !== {4'b1000, 1'b0, 32'h203, 32'hA5A5_1234}) begin
                errors++;
                $display("FAIL wr_hold_%0d: we=%b re=%b addr=%h wdata=%h, expected 1000 0 00000203 a5a51234",
                         c, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
            end
        end
        @(posedge clk); #1;                       // ack cycle
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.d_rvalid, bus.d_rdata} !== {4'b0000, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wr_ack: we=%b re=%b d_rvalid=%b d_rdata=%h, expected 0000 0 1 00000000",
                     bus.mem_we, bus.mem_re, bus.d_rvalid, bus.d_rdata);
        end
        @(negedge clk);
        checks++;
        if (bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse: d_rvalid=%b one cycle after ack, expected 0", bus.d_rvalid);
        end
        wait_drain(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL wr_drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_fetch_stray();
        bit to;
        @(posedge clk); #1;                       // cycle 0
        bus.d_we = 4'b0000;
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        sb.push_back('{fetch: 1'b1, data: 32'h1234_5678});
        @(negedge clk);
        checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL f_gnt: d_gnt,i_gnt=%b, expected 01", {bus.d_gnt, bus.i_gnt});
        end
        @(posedge clk); #1;                       // cycle 1: ISSUE, stray rvalid
        bus.i_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        checks++;
        if ({bus.mem_re, bus.mem_we, bus.mem_addr} !== {1'b1, 4'b0000, 32'h400}) begin
            errors++;
            $display("FAIL f_issue: re=%b we=%b addr=%h, expected 1 0000 00000400",
                     bus.mem_re, bus.mem_we, bus.mem_addr);
        end
        @(posedge clk); #1;                       // cycle 2: ISSUE, ready
        man_rvalid = 1'b0; man_ready = 1'b1;
        @(posedge clk); #1;                       // cycle 3: WAIT, nothing
        man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.i_rvalid, bus.mem_re} !== 2'b00) begin
            errors++;
            $display("FAIL f_stray: i_rvalid=%b mem_re=%b in WAIT, expected 0 0", bus.i_rvalid, bus.mem_re);
        end
        @(posedge clk); #1;                       // cycle 4: WAIT, real data
        man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        @(posedge clk); #1;                       // cycle 5: response
        man_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'h1234_5678}) begin
            errors++;
            $display("FAIL f_resp: i_rvalid=%b d_rvalid=%b i_rdata=%h, expected 1 0 12345678",
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
        end
        @(posedge clk); #1;                       // cycle 6: IDLE, stray handshakes
        man_rvalid = 1'b1; man_ready = 1'b1; man_rdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        man_rvalid = 1'b0; man_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.mem_re, bus.i_rdata} !== {3'b000, 32'h1234_5678}) begin
            errors++;
            $display("FAIL f_idle_stray: i_rvalid=%b d_rvalid=%b re=%b i_rdata=%h, expected 0 0 0 12345678",
                     bus.i_rvalid, bus.d_rvalid, bus.mem_re, bus.i_rdata);
        end
        wait_drain(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL f_drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Both requesters held high: D,D,D,D,I repeating, reads spaced 3 cycles.
    task automatic test_back_to_back();
        logic exp_fetch [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int   n;
        int   last_cyc;
        bit   to;
        n        = 0;
        last_cyc = 0;
        auto_mem = 1'b1;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_addr = 32'h1000; bus.d_we = 4'b0000;
        bus.i_req = 1'b1; bus.i_addr = 32'h2000;
        for (int k = 0; k < 10; k++) begin
            sb.push_back('{fetch: exp_fetch[k], data: mem_fn(exp_fetch[k] ? 32'h2000 : 32'h1000)});
        end
        for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
            @(negedge clk);
            if (bus.d_gnt || bus.i_gnt) begin
                checks++;
                if (bus.i_gnt !== exp_fetch[n]) begin
                    errors++;
                    $display("FAIL b2b_order_%0d: fetch granted=%b, expected %b", n, bus.i_gnt, exp_fetch[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: %0d cycles, expected 3", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
            end
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL b2b_count: %0d grants seen, expected 10", n);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.i_req = 1'b0;
        wait_drain(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
        auto_mem = 1'b0;
    endtask

    // Writes with immediate ready: grants every 2 cycles.
    task automatic test_write_spacing();
        int n;
        int last_cyc;
        bit to;
        n        = 0;
        last_cyc = 0;
        auto_mem = 1'b1;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_addr = 32'h3000; bus.d_wdata = 32'h0F0F_0F0F; bus.d_we = 4'b0011;
        for (int k = 0; k < 3; k++) sb.push_back('{fetch: 1'b0, data: 32'h0});
        for (int cyc = 0; cyc < 100 && n < 3; cyc++) begin
            @(negedge clk);
            if (bus.d_gnt) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        errors++;
                        $display("FAIL wr_spacing_%0d: %0d cycles, expected 2", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wr_count: %0d grants seen, expected 3", n);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 4'b0000;
        wait_drain(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL wr_sp_drain: %0d responses missing, expected 0", sb.size());
            sb.delete();
        end
        auto_mem = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;                       // cycle 0: grant, nothing queued
        bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_we = 4'b0000;
        @(posedge clk); #1;                       // cycle 1: ISSUE
        bus.d_req = 1'b0; man_ready = 1'b1;
        @(posedge clk); #1;                       // cycle 2: WAIT
        man_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid, bus.mem_re, bus.mem_we,
             bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.i_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_async: re=%b we=%b addr=%h wdata=%h drd=%h ird=%h, required all 0",
                     bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_rdata, bus.i_rdata);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;                       // two cycles after release
        man_rvalid = 1'b1; man_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.i_rdata} !== '0) begin
                errors++;
                $display("FAIL rst_late_rvalid_%0d: d_rvalid=%b i_rvalid=%b drd=%h ird=%h, expected all 0",
                         c, bus.d_rvalid, bus.i_rvalid, bus.d_rdata, bus.i_rdata);
            end
        end
        @(posedge clk); #1;                       // IDLE grants at once
        bus.d_req = 1'b1; bus.d_addr = 32'h600;
        #1;
        checks++;
        if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rst_idle: d_gnt,i_gnt=%b, expected 10", {bus.d_gnt, bus.i_gnt});
        end
        bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        auto_mem   = 1'b0;
        man_ready  = 1'b0;
        man_rvalid = 1'b0;
        man_rdata  = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.d_we   = '0;
        bus.i_req  = 1'b0;
        bus.i_addr = '0;
        repeat (2) @(posedge clk);

        test_reset();
        test_data_read();
        test_data_write();
        test_fetch_stray();
        test_back_to_back();
        test_write_spacing();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
